reg_file_mp: RTL and testbench

- Parametrised successor to the single-write, dual-read register file. Sits between decode and execute in the processor datapath.
- Adds N read ports, byte-enabled writes and write-first bypass with registered reads.
- Adds a per-register busy scoreboard: pending writes from in-flight instructions are visible to the hazard logic.

---
 rtl/reg_file_mp.sv | 99 +++++++++
 tb/tb_reg_file_mp.sv | 138 +++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with byte-enabled writes, write-first bypass,
// registered reads and a per-register busy scoreboard for hazard detection.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           writeEnable,
    input  logic [ADDR_WIDTH-1:0]          writeAddress,
    input  logic [DATA_WIDTH-1:0]          writeData,
    input  logic [DATA_WIDTH/8-1:0]        writeByteEnable,
    input  logic                           issueValid,
    input  logic [ADDR_WIDTH-1:0]          issueAddress,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    output logic [NUM_READ-1:0]            readBusy,
    output logic [2**ADDR_WIDTH-1:0]       busyVector
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH/8;

    logic [DATA_WIDTH-1:0]          mem_q [DEPTH];
    logic [DEPTH-1:0]               busy_q;
    logic [DEPTH-1:0]               busy_d;
    logic [DATA_WIDTH-1:0]          wr_merged_d;
    logic                           wr_commit_s;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_d;
    logic [NUM_READ-1:0]            rd_busy_q;
    logic [NUM_READ-1:0]            rd_busy_d;

    // Stored word merged with the enabled bytes of the incoming write.
    always_comb begin
        wr_merged_d = mem_q[writeAddress];
        for (int b = 0; b < NBYTES; b++) begin
            if (writeByteEnable[b]) begin
                wr_merged_d[8*b +: 8] = writeData[8*b +: 8];
            end else begin
                wr_merged_d[8*b +: 8] = mem_q[writeAddress][8*b +: 8];
            end
        end
        wr_commit_s = writeEnable &&
                      !(ZERO_REG && (writeAddress == {ADDR_WIDTH{1'b0}}));
    end

    // Scoreboard update: a new issue to the same register wins over the clearing write.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[i] = (ZERO_REG && (i == 0)) ? 1'b0 :
                        (issueValid  && (issueAddress == ADDR_WIDTH'(i)))  ? 1'b1 :
                        (writeEnable && (writeAddress == ADDR_WIDTH'(i)))  ? 1'b0 :
                        busy_q[i];
        end
    end

    // Read ports see the post-write data and post-update busy bit of their address.
    always_comb begin
        rd_data_d = {(NUM_READ*DATA_WIDTH){1'b0}};
        rd_busy_d = {NUM_READ{1'b0}};
        for (int p = 0; p < NUM_READ; p++) begin
            rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] =
                (ZERO_REG && (readAddress[p*ADDR_WIDTH +: ADDR_WIDTH] == {ADDR_WIDTH{1'b0}}))
                    ? {DATA_WIDTH{1'b0}} :
                (wr_commit_s && (writeAddress == readAddress[p*ADDR_WIDTH +: ADDR_WIDTH]))
                    ? wr_merged_d :
                mem_q[readAddress[p*ADDR_WIDTH +: ADDR_WIDTH]];
            rd_busy_d[p] = busy_d[readAddress[p*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    // State registers; reset clears storage and discards all pending producers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            busy_q    <= {DEPTH{1'b0}};
            rd_data_q <= {(NUM_READ*DATA_WIDTH){1'b0}};
            rd_busy_q <= {NUM_READ{1'b0}};
        end else begin
            if (wr_commit_s) begin
                mem_q[writeAddress] <= wr_merged_d;
            end
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign readData   = rd_data_q;
    assign readBusy   = rd_busy_q;
    assign busyVector = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and random checks of reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [3:0]  writeByteEnable;
    logic        issueValid;
    logic [4:0]  issueAddress;
    logic [9:0]  readAddress;
    logic [63:0] readData;
    logic [1:0]  readBusy;
    logic [31:0] busyVector;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] exp_rd [2];
    bit          exp_bz [2];

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeAddress(writeAddress),
        .writeData(writeData), .writeByteEnable(writeByteEnable), .issueValid(issueValid),
        .issueAddress(issueAddress), .readAddress(readAddress), .readData(readData),
        .readBusy(readBusy), .busyVector(busyVector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: model computes expected outputs, DUT is sampled after the edge.
    task automatic step(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input bit iv, input logic [4:0] ia,
                        input logic [4:0] ra0, input logic [4:0] ra1);
        logic [31:0] mask;
        logic [31:0] merged;
        logic [4:0]  ra [2];
        logic [31:0] exp_bv;
        @(negedge clk);
        reset = rst; writeEnable = we; writeAddress = wa; writeData = wd;
        writeByteEnable = be; issueValid = iv; issueAddress = ia;
        readAddress = {ra1, ra0};
        ra[0] = ra0; ra[1] = ra1;
        mask = 32'd0;
        for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8*b));
        merged = (m_mem[wa] & ~mask) | (wd & mask);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_mem[i] = 32'd0; m_busy[i] = 1'b0; end
        end else begin
            if (we && wa != 5'd0) m_mem[wa] = merged;
            if (we) m_busy[wa] = 1'b0;
            if (iv && ia != 5'd0) m_busy[ia] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            exp_rd[p] = (ra[p] == 5'd0) ? 32'd0 : m_mem[ra[p]];
            exp_bz[p] = (ra[p] == 5'd0) ? 1'b0 : m_busy[ra[p]];
        end
        exp_bv = 32'd0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) exp_bv = exp_bv + (32'd1 << i);
        @(posedge clk);
        #1;
        chk("rd0", {32'd0, readData[31:0]},  {32'd0, exp_rd[0]});
        chk("rd1", {32'd0, readData[63:32]}, {32'd0, exp_rd[1]});
        chk("bz0", {63'd0, readBusy[0]}, {63'd0, exp_bz[0]});
        chk("bz1", {63'd0, readBusy[1]}, {63'd0, exp_bz[1]});
        chk("busyvec", {32'd0, busyVector}, {32'd0, exp_bv});
    endtask

    initial begin
        reset = 1'b0; writeEnable = 1'b0; writeAddress = 5'd0; writeData = 32'd0;
        writeByteEnable = 4'd0; issueValid = 1'b0; issueAddress = 5'd0; readAddress = 10'd0;
        for (int i = 0; i < 32; i++) begin m_mem[i] = 32'd0; m_busy[i] = 1'b0; end

        // Reset, then read every address on both ports
        step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd3, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));

        // Byte-enabled partial write
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd1, 5'd1);
        step(1'b0, 1'b1, 5'd5, 32'h000000AA, 4'h1, 1'b0, 5'd0, 5'd1, 5'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        chk("r5_merge", {32'd0, readData[31:0]}, 64'h0000_0000_DEAD_BEAA);
        chk("r5_same_both", {32'd0, readData[63:32]}, 64'h0000_0000_DEAD_BEAA);

        // Write-first bypass on port 0, untouched r3 on port 1
        step(1'b0, 1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, 5'd0, 5'd7, 5'd3);
        chk("bypass_p0", {32'd0, readData[31:0]}, 64'h0000_0000_1234_5678);
        chk("bypass_p1_old", {32'd0, readData[63:32]}, 64'd0);

        // Scoreboard set / clear / set-wins
        step(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        chk("busy9_set", {63'd0, readBusy[0]}, 64'd1);
        step(1'b0, 1'b1, 5'd9, 32'hCAFE0009, 4'hF, 1'b0, 5'd0, 5'd9, 5'd9);
        chk("busy9_clr", {63'd0, readBusy[0]}, 64'd0);
        chk("r9_data", {32'd0, readData[31:0]}, 64'h0000_0000_CAFE_0009);
        step(1'b0, 1'b1, 5'd9, 32'h0000_1111, 4'h3, 1'b1, 5'd9, 5'd9, 5'd0);
        chk("busy9_setwins", {63'd0, busyVector[9]}, 64'd1);

        // Register zero: write and issue are ignored, bypass included
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("r0_data", readData, 64'd0);
        chk("r0_busyvec0", {63'd0, busyVector[0]}, 64'd0);

        // Reset mid-operation with pending busy bits and a concurrent write
        step(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd2, 5'd2, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd4, 5'd2, 5'd4);
        step(1'b0, 1'b1, 5'd6, 32'h6666_6666, 4'hF, 1'b0, 5'd0, 5'd6, 5'd2);
        step(1'b1, 1'b1, 5'd6, 32'h7777_7777, 4'hF, 1'b0, 5'd0, 5'd6, 5'd4);
        chk("rst_busyvec", {32'd0, busyVector}, 64'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0, 5'd6, 5'd5);
        chk("r6_after_rst", readData, 64'd0);

        // Random traffic, addresses biased toward collisions
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a [4];
            for (int k = 0; k < 4; k++)
                a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1, a[0], 32'($urandom()),
                 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, a[1], a[2],
                 ($urandom_range(0, 3) == 0) ? a[2] : a[3]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
